// File: rtl/proc_pkg.sv
// Shared types and constants for the processor memory subsystem.
// Widths here must stay in step with the simple_ALU memory bus.
package proc_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MEM_ADDR_W = 8;

  typedef enum logic [1:0] {
    MEM_CLEAR = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_RUN   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/proc_sp_ram.sv
// Single-port synchronous RAM with registered read data; a read and write
// to the same address in one cycle returns the old contents. No reset.
module proc_sp_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_we,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
    rdata_q <= mem[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/proc_data_mem.sv
// Data/program memory for simple_ALU: self-clears after reset, accepts an
// image over a valid/ready load port, then serves the processor bus.
module proc_data_mem #(
  parameter int unsigned ADDR_W = proc_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = proc_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_memAddr,
  input  logic [DATA_W-1:0] i_memData,
  input  logic              i_memWrEnable,
  output logic [DATA_W-1:0] o_memData,
  input  logic              i_ldValid,
  input  logic [DATA_W-1:0] i_ldData,
  input  logic              i_ldLast,
  output logic              o_ldReady,
  output logic              o_busy,
  output logic              o_addrErr
);

  import proc_pkg::*;

  mem_state_t        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [ADDR_W-1:0] ld_ptr_q;
  logic              ld_ready_q;
  logic              busy_q;
  logic              addr_err_q;
  logic              rd_ok_q;

  logic              in_range;
  logic              ld_accept;
  logic              ld_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign in_range  = (i_memAddr[15:ADDR_W] == '0);
  assign ld_accept = (state_q == MEM_LOAD) && ld_ready_q && i_ldValid;
  assign ld_done   = ld_accept && (i_ldLast || (ld_ptr_q == '1));

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (state_q)
      MEM_CLEAR: begin
        ram_addr = clr_cnt_q;
        ram_we   = 1'b1;
      end
      MEM_LOAD: begin
        ram_addr  = ld_ptr_q;
        ram_wdata = i_ldData;
        ram_we    = ld_accept;
      end
      MEM_RUN: begin
        ram_addr  = i_memAddr[ADDR_W-1:0];
        ram_wdata = i_memData;
        ram_we    = i_memWrEnable && in_range;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= MEM_CLEAR;
      clr_cnt_q  <= '0;
      ld_ptr_q   <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      addr_err_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      addr_err_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      case (state_q)
        MEM_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == '1) begin
            state_q    <= MEM_LOAD;
            ld_ready_q <= 1'b1;
          end
        end
        MEM_LOAD: begin
          if (ld_accept) begin
            ld_ptr_q <= ld_ptr_q + ADDR_W'(1);
          end
          if (ld_done) begin
            state_q    <= MEM_RUN;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        MEM_RUN: begin
          addr_err_q <= !in_range;
          rd_ok_q    <= in_range;
        end
        default: state_q <= MEM_CLEAR;
      endcase
    end
  end

  // RAM read data is already registered; rd_ok_q is its registered qualifier,
  // forcing zero outside RUN and for out-of-range reads.
  assign o_memData = rd_ok_q ? ram_rdata : '0;
  assign o_ldReady = ld_ready_q;
  assign o_busy    = busy_q;
  assign o_addrErr = addr_err_q;

  proc_sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .i_we    (ram_we),
    .o_rdata (ram_rdata)
  );

endmodule

// File: tb/tb_proc_data_mem.sv
// Directed self-checking bench for proc_data_mem.
module tb_proc_data_mem;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_memAddr;
  logic [15:0] i_memData;
  logic        i_memWrEnable;
  logic [15:0] o_memData;
  logic        i_ldValid;
  logic [15:0] i_ldData;
  logic        i_ldLast;
  logic        o_ldReady;
  logic        o_busy;
  logic        o_addrErr;

  int total;
  int bad;

  proc_data_mem #(
    .ADDR_W (8),
    .DATA_W (16)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_memAddr     (i_memAddr),
    .i_memData     (i_memData),
    .i_memWrEnable (i_memWrEnable),
    .o_memData     (o_memData),
    .i_ldValid     (i_ldValid),
    .i_ldData      (i_ldData),
    .i_ldLast      (i_ldLast),
    .o_ldReady     (o_ldReady),
    .o_busy        (o_busy),
    .o_addrErr     (o_addrErr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!o_ldReady && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (o_ldReady !== 1'b1) begin
      bad++;
      $display("FAIL %s: ldReady timeout got=%b want=1", name, o_ldReady);
    end
  endtask

  task automatic apply_reset();
    i_rst         = 1'b0;
    i_memAddr     = '0;
    i_memData     = '0;
    i_memWrEnable = 1'b0;
    i_ldValid     = 1'b0;
    i_ldData      = '0;
    i_ldLast      = 1'b0;
    tick();
    i_rst = 1'b1;
  endtask

  task automatic read_check(input logic [15:0] addr, input logic [15:0] exp, input string name);
    i_memAddr     = addr;
    i_memWrEnable = 1'b0;
    tick();
    total++;
    if (o_memData !== exp) begin
      bad++;
      $display("FAIL %s: addr=%h memData got=%h want=%h", name, addr, o_memData, exp);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    #2;
    i_rst = 1'b0;
    #1;
    total++;
    if (o_memData !== 16'h0 || o_ldReady !== 1'b0 || o_busy !== 1'b1 || o_addrErr !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got md=%h rdy=%b busy=%b err=%b want 0000/0/1/0",
               o_memData, o_ldReady, o_busy, o_addrErr);
    end
  endtask

  task automatic test_clear();
    int errs;
    apply_reset();
    errs = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (o_ldReady !== 1'b0 || o_busy !== 1'b1 || o_memData !== 16'h0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL clear_busy: %0d bad cycles during clear, want 0", errs);
    end
    tick();
    total++;
    if (o_ldReady !== 1'b1 || o_busy !== 1'b1 || o_memData !== 16'h0) begin
      bad++;
      $display("FAIL clear_to_load: rdy=%b busy=%b md=%h want 1/1/0000", o_ldReady, o_busy, o_memData);
    end
  endtask

  task automatic test_load_small();
    i_ldValid = 1'b1;
    i_ldLast  = 1'b0;
    i_ldData  = 16'h1111;
    i_memAddr = 16'h0003;
    i_memData = 16'h7777;
    i_memWrEnable = 1'b1;
    tick();
    i_ldData = 16'h2222;
    tick();
    i_ldData = 16'h3333;
    i_ldLast = 1'b1;
    total++;
    if (o_busy !== 1'b1 || o_ldReady !== 1'b1) begin
      bad++;
      $display("FAIL load_pre_last: busy=%b rdy=%b want 1/1", o_busy, o_ldReady);
    end
    tick();
    i_ldValid = 1'b0;
    i_ldLast  = 1'b0;
    i_memWrEnable = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_ldReady !== 1'b0) begin
      bad++;
      $display("FAIL load_to_run: busy=%b rdy=%b want 0/0", o_busy, o_ldReady);
    end
    read_check(16'h0000, 16'h1111, "run_rd0");
    read_check(16'h0001, 16'h2222, "run_rd1");
    read_check(16'h0002, 16'h3333, "run_rd2");
    read_check(16'h0003, 16'h0000, "run_rd3");
  endtask

  task automatic test_rbw();
    i_memAddr     = 16'h0010;
    i_memData     = 16'hBEEF;
    i_memWrEnable = 1'b1;
    tick();
    total++;
    if (o_memData !== 16'h0000 || o_addrErr !== 1'b0) begin
      bad++;
      $display("FAIL rbw_old: md=%h err=%b want 0000/0", o_memData, o_addrErr);
    end
    read_check(16'h0010, 16'hBEEF, "rbw_new");
  endtask

  task automatic test_addr_err();
    i_memAddr     = 16'h0100;
    i_memData     = 16'hDEAD;
    i_memWrEnable = 1'b1;
    tick();
    total++;
    if (o_addrErr !== 1'b1 || o_memData !== 16'h0000) begin
      bad++;
      $display("FAIL oor_first: err=%b md=%h want 1/0000", o_addrErr, o_memData);
    end
    i_memAddr = 16'hFF00;
    tick();
    total++;
    if (o_addrErr !== 1'b1 || o_memData !== 16'h0000) begin
      bad++;
      $display("FAIL oor_second: err=%b md=%h want 1/0000", o_addrErr, o_memData);
    end
    read_check(16'h0000, 16'h1111, "oor_no_alias");
    total++;
    if (o_addrErr !== 1'b0) begin
      bad++;
      $display("FAIL oor_clear: err=%b want 0", o_addrErr);
    end
  endtask

  task automatic test_auto_terminate();
    int early;
    apply_reset();
    wait_ready("auto_wait");
    early = 0;
    i_ldValid = 1'b1;
    i_ldLast  = 1'b0;
    for (int w = 0; w < 256; w++) begin
      if (o_ldReady !== 1'b1 || o_busy !== 1'b1) early++;
      i_ldData = 16'h5A00 ^ 16'(w);
      tick();
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL auto_ready: %0d words saw rdy/busy low, want 0", early);
    end
    total++;
    if (o_ldReady !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL auto_run: rdy=%b busy=%b want 0/0", o_ldReady, o_busy);
    end
    i_ldData = 16'hCAFE;
    tick();
    i_ldValid = 1'b0;
    total++;
    if (o_ldReady !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL auto_257th: rdy=%b busy=%b want 0/0", o_ldReady, o_busy);
    end
    read_check(16'h00FF, 16'h5AFF, "auto_rd_ff");
    read_check(16'h0000, 16'h5A00, "auto_rd_00");
  endtask

  task automatic test_reset_midload();
    apply_reset();
    wait_ready("midload_wait1");
    i_ldValid = 1'b1;
    i_ldLast  = 1'b0;
    for (int w = 0; w < 10; w++) begin
      i_ldData = 16'h0100 + 16'(w);
      tick();
    end
    i_ldValid = 1'b0;
    i_rst = 1'b0;
    #1;
    total++;
    if (o_memData !== 16'h0 || o_ldReady !== 1'b0 || o_busy !== 1'b1 || o_addrErr !== 1'b0) begin
      bad++;
      $display("FAIL midload_reset: md=%h rdy=%b busy=%b err=%b want 0000/0/1/0",
               o_memData, o_ldReady, o_busy, o_addrErr);
    end
    tick();
    i_rst = 1'b1;
    wait_ready("midload_wait2");
    i_ldValid = 1'b1;
    i_ldLast  = 1'b1;
    i_ldData  = 16'hAAAA;
    tick();
    i_ldValid = 1'b0;
    i_ldLast  = 1'b0;
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL midload_one_word: busy=%b want 0", o_busy);
    end
    read_check(16'h0005, 16'h0000, "midload_rd5");
    read_check(16'h0000, 16'hAAAA, "midload_rd0");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    i_memAddr     = '0;
    i_memData     = '0;
    i_memWrEnable = 1'b0;
    i_ldValid     = 1'b0;
    i_ldData      = '0;
    i_ldLast      = 1'b0;
    test_reset();
    test_clear();
    test_load_small();
    test_rbw();
    test_addr_err();
    test_auto_terminate();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
